// File: rtl/pc_link_stack.sv
// ---------------------------------------------------------------------------
// pc_link_stack
//
// Purpose:
//   Produces the link value for the register file. The link is the PC, or
//   the PC plus LINK_OFFSET for opcodes that need the incremented link.
//   The block also keeps a hardware return-address stack for call/return
//   opcodes. The stack reports full/empty status and has sticky
//   overflow/underflow flags. A push while full can either be dropped or
//   overwrite the oldest entry, as set by WRAP_ON_FULL.
//
// Ports:
//   clock                           in   rising-edge clock
//   reset                           in   synchronous, active-high reset
//   program_counter  [PC_WIDTH]     in   current PC
//   operation        [OP_WIDTH]     in   decoded opcode at program_counter
//   enable                          in   instruction valid this cycle
//   stall                           in   pipeline hold, blocks stack updates
//   flush                           in   clears stack and flags next edge
//   registers_file_program_counter  out  link value (combinational)
//   return_pc        [PC_WIDTH]     out  top of stack, 0 when empty
//   stack_full                      out  count == DEPTH
//   stack_empty                     out  count == 0
//   overflow                        out  sticky, push while full
//   underflow                       out  sticky, pop while empty
// ---------------------------------------------------------------------------
module pc_link_stack #(
    parameter int                    PC_WIDTH     = 12,
    parameter int                    OP_WIDTH     = 6,
    parameter int                    DEPTH        = 4,
    parameter logic [PC_WIDTH-1:0]   LINK_OFFSET  = PC_WIDTH'(1),
    parameter logic [OP_WIDTH-1:0]   INC_LIMIT    = 6'b010011,
    parameter logic [OP_WIDTH-1:0]   OP_EXTRA_INC = 6'b010111,
    parameter logic [OP_WIDTH-1:0]   OP_CALL      = 6'b010100,
    parameter logic [OP_WIDTH-1:0]   OP_RETURN    = 6'b010101,
    parameter bit                    WRAP_ON_FULL = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] program_counter,
    input  logic [OP_WIDTH-1:0] operation,
    input  logic                enable,
    input  logic                stall,
    input  logic                flush,
    output logic [PC_WIDTH-1:0] registers_file_program_counter,
    output logic [PC_WIDTH-1:0] return_pc,
    output logic                stack_full,
    output logic                stack_empty,
    output logic                overflow,
    output logic                underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] entries_q [DEPTH];
    logic [PC_WIDTH-1:0] entries_d [DEPTH];
    logic [PTR_W-1:0]    top_q, top_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic                inc_sel;
    logic [PC_WIDTH-1:0] link_pc;
    logic                upd, push, pop;
    logic                full, empty;
    logic [PTR_W-1:0]    top_next;

    // Link value: this path is purely combinational. It ignores enable
    // and stall, so the register file always sees the correct link.
    assign inc_sel = (operation < INC_LIMIT) || (operation == OP_EXTRA_INC)
                  || (operation == OP_CALL);
    assign link_pc = inc_sel ? (program_counter + LINK_OFFSET) : program_counter;
    assign registers_file_program_counter = link_pc;

    assign upd  = enable & ~stall & ~reset & ~flush;
    assign push = upd & (operation == OP_CALL);
    assign pop  = upd & (operation == OP_RETURN);

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // DEPTH is a power of two, so the pointer wraps naturally.
    assign top_next = top_q + PTR_W'(1);

    always_comb begin
        entries_d   = entries_q;
        top_d       = top_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            top_d       = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (push) begin
            if (!full) begin
                top_d            = top_next;
                entries_d[top_next] = link_pc;
                count_d          = count_q + CNT_W'(1);
            end else begin
                overflow_d = 1'b1;
                // In circular mode, top_next points at the oldest entry.
                // That entry is overwritten, so count stays at DEPTH.
                if (WRAP_ON_FULL) begin
                    top_d               = top_next;
                    entries_d[top_next] = link_pc;
                end
            end
        end else if (pop) begin
            if (!empty) begin
                top_d   = top_q - PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end else begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            top_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            entries_q   <= entries_d;
            top_q       <= top_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign return_pc   = empty ? '0 : entries_q[top_q];
    assign stack_full  = full;
    assign stack_empty = empty;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_pc_link_stack.sv
module tb_pc_link_stack;

    localparam logic [5:0] OP_CALL = 6'b010100;
    localparam logic [5:0] OP_RET  = 6'b010101;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] program_counter;
    logic [5:0]  operation;
    logic        enable, stall, flush;

    logic [11:0] rf0, ret0, rf1, ret1;
    logic        full0, empty0, ovf0, unf0;
    logic        full1, empty1, ovf1, unf1;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clock = ~clock;

    pc_link_stack #(.DEPTH(4), .WRAP_ON_FULL(1'b0)) dut0 (
        .clock(clock), .reset(reset), .program_counter(program_counter),
        .operation(operation), .enable(enable), .stall(stall), .flush(flush),
        .registers_file_program_counter(rf0), .return_pc(ret0),
        .stack_full(full0), .stack_empty(empty0),
        .overflow(ovf0), .underflow(unf0)
    );

    pc_link_stack #(.DEPTH(4), .WRAP_ON_FULL(1'b1)) dut1 (
        .clock(clock), .reset(reset), .program_counter(program_counter),
        .operation(operation), .enable(enable), .stall(stall), .flush(flush),
        .registers_file_program_counter(rf1), .return_pc(ret1),
        .stack_full(full1), .stack_empty(empty1),
        .overflow(ovf1), .underflow(unf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [11:0] pc,
                         input logic en, input logic st, input logic fl);
        operation       = op;
        program_counter = pc;
        enable          = en;
        stall           = st;
        flush           = fl;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(6'd0, 12'h000, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;

        // reset state
        check("rst_empty", empty0, 1);
        check("rst_full", full0, 0);
        check("rst_ret", ret0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_unf", unf0, 0);

        // link value decode
        drive(6'b000101, 12'h010, 1'b0, 1'b0, 1'b0);
        check("link_low_op", rf0, 12'h011);
        drive(6'b010010, 12'h010, 1'b0, 1'b0, 1'b0);
        check("link_below_limit", rf0, 12'h011);
        drive(6'b010011, 12'h010, 1'b0, 1'b0, 1'b0);
        check("link_at_limit", rf0, 12'h010);
        drive(6'b010111, 12'h010, 1'b0, 1'b0, 1'b0);
        check("link_extra_inc", rf0, 12'h011);
        drive(OP_RET, 12'h010, 1'b0, 1'b0, 1'b0);
        check("link_return", rf0, 12'h010);

        // two calls and two returns
        drive(OP_CALL, 12'h100, 1'b1, 1'b0, 1'b0);
        check("link_call", rf0, 12'h101);
        tick();
        check("call1_ret", ret0, 12'h101);
        check("call1_nonempty", empty0, 0);
        drive(OP_CALL, 12'h200, 1'b1, 1'b0, 1'b0);
        tick();
        check("call2_ret", ret0, 12'h201);
        drive(OP_RET, 12'h300, 1'b1, 1'b0, 1'b0);
        check("pop1_during", ret0, 12'h201);
        tick();
        check("pop1_after", ret0, 12'h101);
        check("pop1_nonempty", empty0, 0);
        tick();
        check("pop2_empty", empty0, 1);
        check("pop2_ret", ret0, 0);
        check("pop2_no_unf", unf0, 0);

        // stall and enable gating
        drive(OP_CALL, 12'h300, 1'b1, 1'b1, 1'b0);
        check("stall_link", rf0, 12'h301);
        tick();
        check("stall_no_push", empty0, 1);
        drive(OP_CALL, 12'h300, 1'b0, 1'b0, 1'b0);
        check("dis_link", rf0, 12'h301);
        tick();
        check("dis_no_push", empty0, 1);

        // fill with five calls at PC 1..5
        for (int i = 1; i <= 5; i++) begin
            drive(OP_CALL, 12'(i), 1'b1, 1'b0, 1'b0);
            tick();
            if (i == 3) begin
                check("three_not_full", full0, 0);
            end
            if (i == 4) begin
                check("four_full0", full0, 1);
                check("four_full1", full1, 1);
                check("four_no_ovf", ovf0, 0);
            end
        end
        check("ovf0_set", ovf0, 1);
        check("ovf1_set", ovf1, 1);
        check("full0_after5", full0, 1);
        check("full1_after5", full1, 1);
        check("top0_after5", ret0, 12'h005);
        check("top1_after5", ret1, 12'h006);

        // pops: drop mode yields 5,4,3,2; wrap mode yields 6,5,4,3
        for (int i = 0; i < 4; i++) begin
            drive(OP_RET, 12'h000, 1'b1, 1'b0, 1'b0);
            check("pop_drop", ret0, 32'(5 - i));
            check("pop_wrap", ret1, 32'(6 - i));
            tick();
        end
        check("drained_empty0", empty0, 1);
        check("drained_empty1", empty1, 1);
        check("ovf_sticky", ovf0, 1);

        // flush clears flags
        drive(6'd0, 12'h000, 1'b0, 1'b0, 1'b1);
        tick();
        check("flush_ovf", ovf0, 0);
        check("flush_ovf1", ovf1, 0);

        // underflow and its persistence
        drive(OP_RET, 12'h000, 1'b1, 1'b0, 1'b0);
        tick();
        check("unf_set", unf0, 1);
        check("unf_empty", empty0, 1);
        check("unf_ret", ret0, 0);
        drive(OP_CALL, 12'h010, 1'b1, 1'b0, 1'b0);
        tick();
        check("unf_persist", unf0, 1);
        check("unf_call_ret", ret0, 12'h011);
        drive(6'd0, 12'h000, 1'b0, 1'b0, 1'b1);
        tick();
        check("unf_flushed", unf0, 0);
        check("flush_empty", empty0, 1);

        // PC wrap on push
        drive(OP_CALL, 12'hFFF, 1'b1, 1'b0, 1'b0);
        check("wrap_link", rf0, 12'h000);
        tick();
        check("wrap_push_nonempty", empty0, 0);
        check("wrap_push_ret", ret0, 12'h000);

        // flush together with a call discards the push
        drive(OP_CALL, 12'h050, 1'b1, 1'b0, 1'b1);
        tick();
        check("flushcall_empty", empty0, 1);
        check("flushcall_ret", ret0, 0);
        check("flushcall_ovf", ovf0, 0);
        check("flushcall_unf", unf0, 0);

        // reset together with a call discards the push
        reset = 1'b1;
        drive(OP_CALL, 12'h060, 1'b1, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        drive(6'd0, 12'h000, 1'b0, 1'b0, 1'b0);
        check("rstcall_empty", empty0, 1);
        check("rstcall_ret", ret0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pc_link_stack.md
Name: pc_link_stack

Overview:
- Parametrised successor to the combinational link-PC filter.
- Computes the link/return value for the register file and keeps a hardware return-address stack of configurable depth for call/return opcodes.
- Sits between the program counter register and the register-file writeback / next-PC mux, driven by the decoded operation field.
- Adds a registered stack with full/empty status, sticky overflow/underflow flags, and a selectable overflow policy.

Parameters:
- PC_WIDTH, 12, width of program counter and all stored addresses.
- OP_WIDTH, 6, width of the operation field.
- DEPTH, 4, number of stack entries (power of two, 2..64).
- LINK_OFFSET, 1, value added to program_counter to form the link address.
- INC_LIMIT, 6'b010011, operations strictly below this value select the incremented link.
- OP_EXTRA_INC, 6'b010111, additional operation that selects the incremented link.
- OP_CALL, 6'b010100, operation that pushes the link address.
- OP_RETURN, 6'b010101, operation that pops the stack.
- WRAP_ON_FULL, 0: 0 drops a push when full; 1 overwrites the oldest entry (circular).

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- program_counter  input  PC_WIDTH  current PC.
- operation  input  OP_WIDTH  decoded opcode of the instruction at program_counter.
- enable  input  1  instruction valid this cycle; stack updates only when 1.
- stall  input  1  pipeline hold; blocks stack updates when 1.
- flush  input  1  clears stack contents and flags on the next edge.
- registers_file_program_counter  output  PC_WIDTH  link value to the register file (combinational).
- return_pc  output  PC_WIDTH  top-of-stack address (combinational from registered state); 0 when empty.
- stack_full  output  1  count == DEPTH.
- stack_empty  output  1  count == 0.
- overflow  output  1  sticky; set on a push while full.
- underflow  output  1  sticky; set on a pop while empty.

Behaviour:
- Link value, combinational, independent of enable/stall:
  - program_counter + LINK_OFFSET when operation < INC_LIMIT, operation == OP_EXTRA_INC, or operation == OP_CALL.
  - Otherwise program_counter.
  - Addition is modulo 2^PC_WIDTH, so 12'hFFF + 1 = 12'h000.
- Update condition: upd = enable & ~stall & ~reset & ~flush. Push = upd & (operation == OP_CALL). Pop = upd & (operation == OP_RETURN). Push and pop are mutually exclusive by opcode.
- Registered state:
  - entry array [DEPTH].
  - top pointer (log2 DEPTH bits, wraps modulo DEPTH).
  - count (log2 DEPTH + 1 bits, range 0..DEPTH).
  - overflow and underflow flags.
- Reset, synchronous (same as flush): count = 0, top = 0, overflow = 0, underflow = 0, every entry = 0. Therefore stack_empty = 1, stack_full = 0, return_pc = 0. Reset has priority over flush, flush has priority over push/pop.
- Push, not full: top advances by 1, the entry at the new top = link value, count + 1.
- Push, full, WRAP_ON_FULL = 0: no state change except overflow is set to 1.
- Push, full, WRAP_ON_FULL = 1: top advances and overwrites the oldest entry, count stays DEPTH, overflow is set to 1.
- Pop, not empty: return_pc shows the popped value during the pop cycle. On the edge, top retreats by 1 and count - 1.
- Pop, empty: no state change, underflow is set to 1, return_pc = 0.
- Flags stay set until reset or flush.
- return_pc = entry[top] when count > 0, else 0. New values are visible the cycle after the push edge.
- When stall = 1 or enable = 0, all registered state holds. The link output still tracks its inputs.
- Reset or flush asserted during a call/return cycle: the push/pop is discarded.

Test Plan:
- Reset, then operation = 6'b000101, PC = 12'h010 -> registers_file_program_counter = 12'h011; operation = 6'b010011 -> 12'h010; operation = 6'b010111 -> 12'h011; stack_empty = 1, return_pc = 0.
- Calls at PC 12'h100 and 12'h200, then a return -> return_pc = 12'h201 during the return cycle. After the return: return_pc = 12'h101, count 1. A second return -> empty.
- DEPTH = 4, WRAP_ON_FULL = 0, five calls at PC 1..5 -> after the 4th stack_full = 1, the 5th sets overflow = 1. Four pops yield 5,4,3,2 as return_pc. The stack is then empty.
- WRAP_ON_FULL = 1, same five calls -> overflow = 1, stack_full stays 1. Pops yield 6,5,4,3, then stack_empty = 1.
- Return while empty -> underflow = 1, count stays 0. The flag persists through later calls and clears only on flush.
- Call with stall = 1 or enable = 0 -> no push, yet the link output = PC + 1. Call at PC 12'hFFF -> the pushed value is 12'h000. Flush and call in the same cycle -> stack empty, flags 0.
